mem_received_msg_tx: RTL and testbench

//  Drains received-number reports from the memory manager (valid/ack handshake) and serialises each into a UART message.

---
 rtl/mem_received_msg_tx_pkg.sv | 17 +
 rtl/uart_msg_serializer.sv | 72 +++++++
 rtl/mem_received_msg_tx.sv | 118 +++++++++++
 tb/tb_mem_received_msg_tx.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_received_msg_tx_pkg.sv
// rtl/mem_received_msg_tx_pkg.sv - UART status-message constants shared with the RX decoder
package mem_received_msg_tx_pkg;

  localparam int         MSG_ADDR_WIDTH   = 8;
  localparam int         MSG_DATA_WIDTH   = 16;
  localparam logic [7:0] MSG_HDR_WRONG    = 8'h05;
  localparam logic [7:0] MSG_HDR_REPLACED = 8'h06;
  localparam logic [7:0] MSG_HDR_OVERRUN  = 8'h07;

  typedef logic [7:0] msg_byte_t;

  // Whole bytes needed to carry a field; the spare MSBs are zero-padded.
  function automatic int payload_bytes(input int field_width);
    return (field_width + 7) / 8;
  endfunction

endpackage

// File: rtl/uart_msg_serializer.sv
// rtl/uart_msg_serializer.sv - header plus N-byte payload streamer on a valid/ready byte port
module uart_msg_serializer
  import mem_received_msg_tx_pkg::*;
#(
  parameter int FIELD_WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [7:0]             load_hdr,
  input  logic                   hdr_only,
  input  logic [FIELD_WIDTH-1:0] field,
  input  logic                   tx_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  output logic                   done
);

  localparam int PAYLOAD_BYTES = payload_bytes(FIELD_WIDTH);
  localparam int PW            = 8 * PAYLOAD_BYTES;
  localparam int CTR_W         = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam logic [CTR_W-1:0] LAST_IDX = CTR_W'(PAYLOAD_BYTES - 1);

  logic             in_hdr;
  logic             hdr_only_q;
  logic [CTR_W-1:0] byte_ctr;
  logic [PW-1:0]    shift_q;
  logic [PW-1:0]    padded;
  logic             xfer;
  logic             last;

  always_comb begin
    padded = '0;
    padded[FIELD_WIDTH-1:0] = field;
  end

  // field is only sampled at the header transfer, so it may be registered by the caller on load.
  assign xfer = tx_valid && tx_ready;
  assign last = in_hdr ? hdr_only_q : (byte_ctr == LAST_IDX);
  assign done = xfer && last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      in_hdr     <= 1'b0;
      hdr_only_q <= 1'b0;
      byte_ctr   <= '0;
      shift_q    <= '0;
    end else if (load) begin
      tx_valid   <= 1'b1;
      tx_data    <= load_hdr;
      in_hdr     <= 1'b1;
      hdr_only_q <= hdr_only;
      byte_ctr   <= '0;
    end else if (xfer) begin
      in_hdr <= 1'b0;
      if (last) begin
        tx_valid <= 1'b0;
      end else if (in_hdr) begin
        tx_data  <= padded[PW-1 -: 8];
        shift_q  <= padded << 8;
        byte_ctr <= '0;
      end else begin
        tx_data  <= shift_q[PW-1 -: 8];
        shift_q  <= shift_q << 8;
        byte_ctr <= byte_ctr + CTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/mem_received_msg_tx.sv
// rtl/mem_received_msg_tx.sv - received-number report to UART message transmitter; option OVERRUN_REPORT_EN
module mem_received_msg_tx
  import mem_received_msg_tx_pkg::*;
#(
  parameter int         ADDR_WIDTH   = MSG_ADDR_WIDTH,
  parameter int         DATA_WIDTH   = MSG_DATA_WIDTH,
  parameter logic [7:0] HDR_WRONG    = MSG_HDR_WRONG,
  parameter logic [7:0] HDR_REPLACED = MSG_HDR_REPLACED,
  parameter logic [7:0] HDR_OVERRUN  = MSG_HDR_OVERRUN
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] mem_received_num,
  input  logic                           mem_received_replaced,
  input  logic                           mem_received_valid,
  input  logic                           mem_received_overrun,
  output logic                           mem_received_ack,
  output logic [7:0]                     tx_data,
  output logic                           tx_valid,
  input  logic                           tx_ready,
  output logic                           busy
);

  localparam int NUM_W = ADDR_WIDTH + DATA_WIDTH;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HEADER  = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;
`ifdef OVERRUN_REPORT_EN
  localparam logic [1:0] ST_OVERRUN = 2'd3;
`endif

  logic [1:0]       state;
  logic [1:0]       state_d;
  logic [NUM_W-1:0] num_q;
  logic             ack_q;
  logic             take_ovr;
  logic             capture;
  logic             load;
  logic [7:0]       load_hdr;
  logic             ser_done;

`ifdef OVERRUN_REPORT_EN
  logic ovr_q;
  logic pending_ovr;
  logic ovr_rise;

  assign ovr_rise = mem_received_overrun && !ovr_q;
  assign take_ovr = (state == ST_IDLE) && pending_ovr;

  // A fresh edge wins over the clear so an overrun during the 07 byte is reported again.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovr_q       <= 1'b0;
      pending_ovr <= 1'b0;
    end else begin
      ovr_q <= mem_received_overrun;
      if (ovr_rise)
        pending_ovr <= 1'b1;
      else if ((state == ST_OVERRUN) && ser_done)
        pending_ovr <= 1'b0;
    end
  end
`else
  logic unused_ovr;
  assign unused_ovr = mem_received_overrun;
  assign take_ovr   = 1'b0;
`endif

  assign capture  = (state == ST_IDLE) && !take_ovr && mem_received_valid;
  assign load     = capture || take_ovr;
  assign load_hdr = take_ovr ? HDR_OVERRUN :
                    (mem_received_replaced ? HDR_REPLACED : HDR_WRONG);

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:    if (capture) state_d = ST_HEADER;
      ST_HEADER:  if (tx_valid && tx_ready) state_d = ST_PAYLOAD;
      ST_PAYLOAD: if (ser_done) state_d = ST_IDLE;
      default:    if (ser_done) state_d = ST_IDLE;
    endcase
`ifdef OVERRUN_REPORT_EN
    if (take_ovr) state_d = ST_OVERRUN;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      ack_q <= 1'b0;
      num_q <= '0;
    end else begin
      state <= state_d;
      ack_q <= capture;
      if (capture) num_q <= mem_received_num;
    end
  end

  uart_msg_serializer #(
    .FIELD_WIDTH(NUM_W)
  ) u_serializer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_hdr (load_hdr),
    .hdr_only (take_ovr),
    .field    (num_q),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .done     (ser_done)
  );

  assign mem_received_ack = ack_q;
  assign busy             = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_received_msg_tx.sv
// tb/tb_mem_received_msg_tx.sv - self-checking bench for mem_received_msg_tx
module tb_mem_received_msg_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] mem_received_num;
  logic        mem_received_replaced;
  logic        mem_received_valid;
  logic        mem_received_overrun;
  logic        mem_received_ack;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         got_cyc[$];
  int cyc = 0;
  int stall_viol = 0, stall_seen = 0, ack_count = 0, ack_viol = 0;
  int ready_mode = 0;

  mem_received_msg_tx dut (
    .clk                   (clk),
    .reset                 (reset),
    .mem_received_num      (mem_received_num),
    .mem_received_replaced (mem_received_replaced),
    .mem_received_valid    (mem_received_valid),
    .mem_received_overrun  (mem_received_overrun),
    .mem_received_ack      (mem_received_ack),
    .tx_data               (tx_data),
    .tx_valid              (tx_valid),
    .tx_ready              (tx_ready),
    .busy                  (busy)
  );

  always #5 clk = ~clk;

  // Observer: records transferred bytes and stream/ack rule violations at the falling edge.
  logic       prev_stall = 1'b0, prev_ack = 1'b0, prev_busy = 1'b0;
  logic [7:0] prev_data = 8'h00;
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      prev_stall = 1'b0;
      prev_ack   = 1'b0;
      prev_busy  = 1'b0;
    end else begin
      if (prev_stall) begin
        stall_seen++;
        if (tx_valid !== 1'b1 || tx_data !== prev_data) stall_viol++;
      end
      if (mem_received_ack) begin
        ack_count++;
        if (prev_ack || prev_busy) ack_viol++;
      end
      if (tx_valid && tx_ready) begin
        got_q.push_back(tx_data);
        got_cyc.push_back(cyc);
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      prev_ack   = mem_received_ack;
      prev_busy  = busy;
    end
  end

  // Transmitter model: 0 always ready, 1 three stall cycles per byte, 2 random.
  int hold = 0;
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: tx_ready = 1'b1;
        1: begin
          if (tx_valid) begin
            if (hold == 3) begin tx_ready = 1'b1; hold = 0; end
            else begin tx_ready = 1'b0; hold++; end
          end else begin
            tx_ready = 1'b0;
            hold = 0;
          end
        end
        default: tx_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Reference: header from the replaced flag, then the 24-bit number high byte first.
  task automatic model_push(input logic [23:0] num, input logic repl);
    exp_q.push_back(repl ? 8'h06 : 8'h05);
    for (int k = 2; k >= 0; k--) exp_q.push_back(8'((num >> (8 * k)) & 24'hFF));
  endtask

  task automatic clear_scoreboard;
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic send_report(input logic [23:0] num, input logic repl, output bit acked);
    acked = 1'b0;
    mem_received_num      = num;
    mem_received_replaced = repl;
    mem_received_valid    = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (mem_received_ack) begin acked = 1'b1; break; end
    end
    mem_received_valid = 1'b0;
  endtask

  task automatic wait_drain(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (got_q.size() >= exp_q.size() && !busy && !mem_received_valid) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got=%b want=0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got=%h want=00", tx_data); end
    checks++; if (mem_received_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b want=0", mem_received_ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset valid=%b busy=%b want=0/0", tx_valid, busy); end
  endtask

  task automatic test_basic(input logic repl);
    bit acked, to;
    int a0, v0;
    clear_scoreboard();
    a0 = ack_count; v0 = ack_viol;
    ready_mode = 0;
    @(posedge clk); #1;
    model_push(24'h12ABCD, repl);
    send_report(24'h12ABCD, repl, acked);
    checks++; if (!acked) begin errors++; $display("FAIL basic_ack_timeout repl=%b got=0 want=1", repl); end
    wait_drain(to);
    checks++; if (to) begin errors++; $display("FAIL basic_drain_timeout got=%0d bytes want=%0d", got_q.size(), exp_q.size()); end
    checks++; if (got_q.size() != 4) begin errors++; $display("FAIL basic_len got=%0d want=4", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL basic_byte%0d got=%h want=%h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
    checks++; if (got_cyc.size() != 4 || got_cyc[3] - got_cyc[0] != 3) begin errors++; $display("FAIL basic_back_to_back span got=%0d want=3", (got_cyc.size() == 4) ? got_cyc[3] - got_cyc[0] : -1); end
    checks++; if (ack_count - a0 != 1) begin errors++; $display("FAIL basic_ack_count got=%0d want=1", ack_count - a0); end
    checks++; if (ack_viol != v0) begin errors++; $display("FAIL basic_ack_pulse got=%0d want=0", ack_viol - v0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got=%b want=0", busy); end
  endtask

  task automatic test_stall;
    bit acked, to;
    int a0, s0, n0;
    clear_scoreboard();
    a0 = ack_count; s0 = stall_viol; n0 = stall_seen;
    ready_mode = 1;
    @(posedge clk); #1;
    model_push(24'h12ABCD, 1'b0);
    send_report(24'h12ABCD, 1'b0, acked);
    wait_drain(to);
    checks++; if (!acked || to) begin errors++; $display("FAIL stall_timeout acked=%b timed_out=%b want=1/0", acked, to); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL stall_len got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL stall_byte%0d got=%h want=%h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
    checks++; if (stall_viol != s0) begin errors++; $display("FAIL stall_hold violations=%0d want=0", stall_viol - s0); end
    checks++; if (stall_seen - n0 < 12) begin errors++; $display("FAIL stall_cycles got=%0d want>=12", stall_seen - n0); end
    checks++; if (ack_count - a0 != 1) begin errors++; $display("FAIL stall_ack_count got=%0d want=1", ack_count - a0); end
    ready_mode = 0;
  endtask

  task automatic test_back_to_back;
    bit acked, to;
    int a0, at_second;
    clear_scoreboard();
    a0 = ack_count;
    ready_mode = 2;
    @(posedge clk); #1;
    model_push(24'h12ABCD, 1'b0);
    model_push(24'h3456EF, 1'b1);
    send_report(24'h12ABCD, 1'b0, acked);
    send_report(24'h3456EF, 1'b1, acked);
    at_second = got_q.size();
    checks++; if (!acked) begin errors++; $display("FAIL b2b_second_ack got=0 want=1"); end
    checks++; if (at_second != 4) begin errors++; $display("FAIL b2b_ack_before_idle bytes_done=%0d want=4", at_second); end
    wait_drain(to);
    checks++; if (to) begin errors++; $display("FAIL b2b_drain_timeout got=%0d want=%0d", got_q.size(), exp_q.size()); end
    checks++; if (got_q.size() != 8) begin errors++; $display("FAIL b2b_len got=%0d want=8", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL b2b_byte%0d got=%h want=%h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
    checks++; if (ack_count - a0 != 2) begin errors++; $display("FAIL b2b_ack_count got=%0d want=2", ack_count - a0); end
    ready_mode = 0;
  endtask

  task automatic test_reset_mid;
    bit acked, to, reached;
    clear_scoreboard();
    ready_mode = 0;
    @(posedge clk); #1;
    send_report(24'h12ABCD, 1'b0, acked);
    reached = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (got_q.size() >= 2) begin reached = 1'b1; break; end
      @(posedge clk); #1;
    end
    checks++; if (!reached) begin errors++; $display("FAIL rstmid_reach got=%0d bytes want=2", got_q.size()); end
    reset = 1'b1;
    #1;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b want=0", tx_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL rstmid_no_tail got=%0d bytes want=2", got_q.size()); end
    exp_q.push_back(8'h05);
    exp_q.push_back(8'h12);
    model_push(24'h12ABCD, 1'b0);
    send_report(24'h12ABCD, 1'b0, acked);
    wait_drain(to);
    checks++; if (!acked || to) begin errors++; $display("FAIL rstmid_timeout acked=%b timed_out=%b want=1/0", acked, to); end
    checks++; if (got_q.size() != 6) begin errors++; $display("FAIL rstmid_len got=%0d want=6", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rstmid_byte%0d got=%h want=%h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_random;
    bit acked, to;
    int a0, s0, v0, misses;
    logic [23:0] num;
    logic repl;
    clear_scoreboard();
    a0 = ack_count; s0 = stall_viol; v0 = ack_viol; misses = 0;
    for (int n = 0; n < 20; n++) begin
      ready_mode = $urandom_range(0, 2);
      num  = 24'($urandom);
      repl = 1'($urandom);
`ifndef OVERRUN_REPORT_EN
      mem_received_overrun = 1'($urandom);
`endif
      model_push(num, repl);
      send_report(num, repl, acked);
      if (!acked) misses++;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    wait_drain(to);
    mem_received_overrun = 1'b0;
    checks++; if (misses != 0 || to) begin errors++; $display("FAIL rand_timeout missed_acks=%0d timed_out=%b want=0/0", misses, to); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_len got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rand_byte%0d got=%h want=%h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
    checks++; if (ack_count - a0 != 20) begin errors++; $display("FAIL rand_ack_count got=%0d want=20", ack_count - a0); end
    checks++; if (stall_viol != s0) begin errors++; $display("FAIL rand_stall_hold violations=%0d want=0", stall_viol - s0); end
    checks++; if (ack_viol != v0) begin errors++; $display("FAIL rand_ack_pulse violations=%0d want=0", ack_viol - v0); end
    ready_mode = 0;
  endtask

`ifdef OVERRUN_REPORT_EN
  task automatic test_overrun;
    bit acked, to;
    clear_scoreboard();
    ready_mode = 0;
    mem_received_overrun = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_push(24'h12ABCD, 1'b0);
    send_report(24'h12ABCD, 1'b0, acked);
    mem_received_overrun = 1'b1;
    exp_q.push_back(8'h07);
    wait_drain(to);
    checks++; if (!acked || to) begin errors++; $display("FAIL ovr_timeout acked=%b timed_out=%b want=1/0", acked, to); end
    repeat (20) @(posedge clk);
    #1;
    checks++; if (got_q.size() != 5) begin errors++; $display("FAIL ovr_len got=%0d want=5", got_q.size()); end
    model_push(24'h00BEEF, 1'b1);
    send_report(24'h00BEEF, 1'b1, acked);
    wait_drain(to);
    repeat (10) @(posedge clk);
    #1;
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL ovr_no_repeat got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL ovr_byte%0d got=%h want=%h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
    mem_received_overrun = 1'b0;
  endtask
`endif

  initial begin
    reset                 = 1'b1;
    mem_received_num      = '0;
    mem_received_replaced = 1'b0;
    mem_received_valid    = 1'b0;
    mem_received_overrun  = 1'b0;
    test_reset();
    test_basic(1'b0);
    test_basic(1'b1);
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef OVERRUN_REPORT_EN
    test_overrun();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
